// File: rtl/stream_mux_rr.sv
// stream_mux_rr: CH-input stream multiplexer with valid/ready handshake and a
// single registered output stage. The channel is chosen by an external select
// (mode=0) or by round-robin arbitration (mode=1).
// Optional feature macro: STREAM_MUX_FRAME_LOCK_EN. When it is defined, the
// first granted channel keeps the output for FRAME beats and the last beat of
// the frame is flagged on out_last.
module stream_mux_rr #(
    parameter int unsigned N     = 16,
    parameter int unsigned CH    = 4,
    parameter int unsigned SELW  = $clog2(CH),
    parameter int unsigned FRAME = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SELW-1:0] rr_ptr;
    logic            load;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [N-1:0]    gnt_data;
    logic            xfer;
    logic            last_beat;
    logic            ptr_upd;

`ifdef STREAM_MUX_FRAME_LOCK_EN
    localparam int unsigned CNTW = $clog2(FRAME);

    logic            lock;
    logic [SELW-1:0] lock_ch;
    logic [CNTW-1:0] beat_cnt;
`endif

    // The register accepts a new beat when it is empty or is being drained.
    assign load     = (state == S_EMPTY) | out_ready;
    assign xfer     = gnt_vld & load;
    assign in_ready = xfer ? (CH'(1) << gnt_idx) : '0;
    assign out_valid = (state == S_FULL);

    // Grant selection: the frame lock overrides everything, then fixed select or round-robin.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
`ifdef STREAM_MUX_FRAME_LOCK_EN
        if (lock) begin
            gnt_vld = in_valid[lock_ch];
            gnt_idx = lock_ch;
        end else
`endif
        if (!mode) begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int unsigned i = 0; i < CH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            // Scan from the farthest candidate down, so the nearest channel after rr_ptr wins.
            for (int unsigned k = CH; k >= 1; k--) begin
                if (in_valid[SELW'((32'(rr_ptr) + k) % CH)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'((32'(rr_ptr) + k) % CH);
                end
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = in_data[i*N +: N];
            end
        end
    end

    // Next-state logic for the output register occupancy.
    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY: if (xfer) state_nx = S_FULL;
            S_FULL:  if (out_ready && !xfer) state_nx = S_EMPTY;
            default: state_nx = S_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Output payload register. On a bubble it keeps its last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_ch   <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            out_data <= gnt_data;
            out_ch   <= gnt_idx;
            out_last <= last_beat;
        end
    end

`ifdef STREAM_MUX_FRAME_LOCK_EN
    assign last_beat = lock && (beat_cnt == CNTW'(FRAME - 1));
    // While locked, gnt_idx equals lock_ch, so the pointer ends the frame on lock_ch.
    assign ptr_upd   = xfer & (mode | lock);

    // Frame lock tracking: capture the channel on the first beat and release it after FRAME beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_ch  <= '0;
            beat_cnt <= '0;
        end else if (xfer) begin
            if (!lock) begin
                lock     <= 1'b1;
                lock_ch  <= gnt_idx;
                beat_cnt <= CNTW'(1);
            end else if (last_beat) begin
                lock     <= 1'b0;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNTW'(1);
            end
        end
    end
`else
    assign last_beat = 1'b0;
    assign ptr_upd   = xfer & mode;
`endif

    // Round-robin pointer: the last channel granted in round-robin mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SELW'(CH - 1);
        end else if (ptr_upd) begin
            rr_ptr <= gnt_idx;
        end
    end

endmodule
